// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
//   Shared types and helpers for the multi-precision CLA adder.
//   - cla_mp_state_t : controller states (IDLE -> RUN -> DONE -> IDLE)
//   - idx_width()    : width of the chunk counter for a given chunk count
// -----------------------------------------------------------------------------
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_mp_state_t;

    // A single-chunk adder still needs a 1-bit counter so the signal exists.
    function automatic int idx_width(input int n_chunks);
        return (n_chunks <= 1) ? 1 : $clog2(n_chunks);
    endfunction

endpackage

// File: rtl/cla_mp_adder_if.sv
// -----------------------------------------------------------------------------
// cla_mp_adder_if
//   Operand/result handshake bundle for cla_mp_adder.
//   Parameter W : operand width (N * N_CHUNKS of the attached adder).
//   master : operand source / result consumer side
//            drives in_valid, a, b, c_in, out_ready
//   slave  : the adder
//            drives in_ready, out_valid, y, c_out, busy
// -----------------------------------------------------------------------------
interface cla_mp_adder_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         c_out;
    logic         busy;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, y, c_out, busy
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, y, c_out, busy
    );
endinterface

// File: rtl/cla_mp_adder_cla.sv
// -----------------------------------------------------------------------------
// cla
//   Combinational carry-lookahead adder, 4*N_BLOCKS bits wide.
//   Each 4-bit block resolves its internal carries with full lookahead
//   equations; block carries are chained from block to block.
//   Ports:
//     a, b   in  4*N_BLOCKS  addends
//     c_in   in  1           carry into bit 0
//     y      out 4*N_BLOCKS  sum
//     c_out  out 1           carry out of the top bit
// -----------------------------------------------------------------------------
module cla #(
    parameter int N_BLOCKS = 2
) (
    input  logic [4*N_BLOCKS-1:0] a,
    input  logic [4*N_BLOCKS-1:0] b,
    input  logic                  c_in,
    output logic [4*N_BLOCKS-1:0] y,
    output logic                  c_out
);
    logic [N_BLOCKS:0] blk_carry;

    assign blk_carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < N_BLOCKS; gi++) begin : g_blk
            logic [3:0] g;
            logic [3:0] p;
            logic [4:0] c;

            assign g    = a[gi*4 +: 4] & b[gi*4 +: 4];
            assign p    = a[gi*4 +: 4] ^ b[gi*4 +: 4];
            assign c[0] = blk_carry[gi];
            assign c[1] = g[0] | (p[0] & c[0]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);
            assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                        | (p[3] & p[2] & p[1] & g[0])
                        | (p[3] & p[2] & p[1] & p[0] & c[0]);

            assign y[gi*4 +: 4]   = p ^ c[3:0];
            assign blk_carry[gi+1] = c[4];
        end
    endgenerate

    assign c_out = blk_carry[N_BLOCKS];
endmodule

// File: rtl/cla_mp_adder.sv
// -----------------------------------------------------------------------------
// cla_mp_adder
//   Multi-precision sequential adder: {c_out, y} = a + b + c_in over
//   W = N*N_CHUNKS bits, using one N-bit CLA per cycle, LS chunk first.
//   Ports:
//     clk   in  clock, rising edge
//     rst   in  synchronous active-high reset
//     bus   slave modport of cla_mp_adder_if (in_valid/in_ready, a, b, c_in,
//           out_valid/out_ready, y, c_out, busy)
//   Latency: accept at edge E -> out_valid after edge E+N_CHUNKS.
// -----------------------------------------------------------------------------
module cla_mp_adder
    import cla_pkg::*;
#(
    parameter int N        = 8,
    parameter int N_CHUNKS = 4
) (
    input  logic            clk,
    input  logic            rst,
    cla_mp_adder_if.slave   bus
);
    localparam int W     = N * N_CHUNKS;
    localparam int IDX_W = idx_width(N_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    cla_mp_state_t   state_reg, state_next;
    logic [W-1:0]    a_reg, b_reg, y_reg;
    logic [W-1:0]    y_next;
    logic            carry_reg;
    logic            c_out_reg;
    logic [IDX_W-1:0] idx_reg;

    logic [N-1:0]    chunk_sum;
    logic            chunk_carry;
    logic            accept;
    logic            run_step;
    logic            last_chunk;

    // Operand registers shift right each RUN cycle, so chunk 0 always feeds
    // the adder and no wide chunk-select mux is needed.
    cla #(.N_BLOCKS(N / 4)) u_cla (
        .a     (a_reg[N-1:0]),
        .b     (b_reg[N-1:0]),
        .c_in  (carry_reg),
        .y     (chunk_sum),
        .c_out (chunk_carry)
    );

    assign accept     = (state_reg == IDLE) && bus.in_valid;
    assign run_step   = (state_reg == RUN);
    assign last_chunk = (idx_reg == LAST_IDX);

    // Sum chunks enter at the top of y; after N_CHUNKS shifts chunk 0 has
    // reached the bottom.
    generate
        if (N_CHUNKS == 1) begin : g_y_single
            assign y_next = chunk_sum;
        end else begin : g_y_shift
            assign y_next = {chunk_sum, y_reg[W-1:N]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.in_valid)  state_next = RUN;
            RUN:  if (last_chunk)    state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            y_reg     <= '0;
            carry_reg <= 1'b0;
            c_out_reg <= 1'b0;
            idx_reg   <= '0;
        end else if (accept) begin
            // y is deliberately left alone; it is only meaningful in DONE.
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.c_in;
            idx_reg   <= '0;
        end else if (run_step) begin
            a_reg     <= a_reg >> N;
            b_reg     <= b_reg >> N;
            y_reg     <= y_next;
            carry_reg <= chunk_carry;
            idx_reg   <= idx_reg + IDX_W'(1);
            if (last_chunk) begin
                c_out_reg <= chunk_carry;
            end
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg == RUN) || (state_reg == DONE);
    assign bus.y         = y_reg;
    assign bus.c_out     = c_out_reg;
endmodule

// File: tb/tb_cla_mp_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_mp_adder
//   Directed table vectors and corner sequences on an (8,4) instance, plus
//   random handshake traffic on (8,4), (16,2) and (8,1) instances, all
//   checked through expected-result queues.
// -----------------------------------------------------------------------------
module tb_cla_mp_adder;
    localparam int NTXN      = 1000;
    localparam int CYC_LIMIT = 30000;

    logic clk;
    logic rst0;
    int   tests_run;
    int   tests_failed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- directed instance (N=8, N_CHUNKS=4) ----------------
    cla_mp_adder_if #(.W(32)) bus0 ();
    cla_mp_adder #(.N(8), .N_CHUNKS(4)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    logic [32:0] sb0[$];

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        c_in;
        logic [31:0] y;
        logic        c_out;
    } vec_t;

    vec_t vecs[8];

    // Drive one operand set while IDLE; returns at the negedge after accept.
    task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic c_in,
                         input logic [32:0] e);
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.a        = a;
        bus0.b        = b;
        bus0.c_in     = c_in;
        chk("in_ready_before_accept", 64'(bus0.in_ready), 64'd1);
        sb0.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        bus0.a        = $urandom;
        bus0.b        = $urandom;
        bus0.c_in     = ~c_in;
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_out0(output int lat);
        lat = 0;
        while (!bus0.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic recv0(input string name);
        logic [32:0] e;
        if (sb0.size() == 0) begin
            chk({name, "_queue_nonempty"}, 64'(sb0.size()), 64'd1);
        end else begin
            e = sb0.pop_front();
            bus0.out_ready = 1'b1;
            chk(name, 64'({bus0.c_out, bus0.y}), 64'(e));
            $display("[TB] dir %s y=%h c_out=%b", name, bus0.y, bus0.c_out);
            @(posedge clk);
            @(negedge clk);
            bus0.out_ready = 1'b0;
            chk({name, "_in_ready_after"}, 64'(bus0.in_ready), 64'd1);
            chk({name, "_out_valid_after"}, 64'(bus0.out_valid), 64'd0);
        end
    endtask

    // ---------------- random instances ----------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rand
            localparam int CN  = (gi == 1) ? 16 : 8;
            localparam int CNC = (gi == 0) ? 4 : (gi == 1) ? 2 : 1;
            localparam int CW  = CN * CNC;

            logic        rst_r;
            logic [CW:0] exp_q[$];
            int          sent;
            int          got;
            bit          done;

            cla_mp_adder_if #(.W(CW)) rbus ();
            cla_mp_adder #(.N(CN), .N_CHUNKS(CNC)) rdut (
                .clk (clk),
                .rst (rst_r),
                .bus (rbus)
            );

            initial begin : drv
                logic [CW:0] e;
                rst_r         = 1'b1;
                rbus.in_valid = 1'b0;
                rbus.a        = '0;
                rbus.b        = '0;
                rbus.c_in     = 1'b0;
                sent          = 0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_r = 1'b0;
                while (sent < NTXN && !done) begin
                    @(negedge clk);
                    rbus.in_valid = ($urandom_range(0, 3) != 0);
                    rbus.a        = CW'($urandom);
                    rbus.b        = CW'($urandom);
                    rbus.c_in     = 1'($urandom_range(0, 1));
                    if (rbus.in_valid && rbus.in_ready) begin
                        e = rbus.a + rbus.b + rbus.c_in;
                        exp_q.push_back(e);
                        sent++;
                    end
                end
                @(negedge clk);
                rbus.in_valid = 1'b0;
            end

            initial begin : mon
                logic [CW:0] e;
                int cyc;
                got            = 0;
                cyc            = 0;
                rbus.out_ready = 1'b0;
                repeat (3) @(negedge clk);
                while (got < NTXN && cyc < CYC_LIMIT) begin
                    @(negedge clk);
                    cyc++;
                    rbus.out_ready = 1'($urandom_range(0, 1));
                    if (rbus.out_valid && rbus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk($sformatf("cfg%0d_unexpected_result", gi), 64'd1, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("cfg%0d_txn%0d", gi, got),
                                64'({rbus.c_out, rbus.y}), 64'(e));
                            $display("[TB] cfg%0d txn %0d y=%h c_out=%b",
                                     gi, got, rbus.y, rbus.c_out);
                        end
                        got++;
                    end
                end
                chk($sformatf("cfg%0d_results_received", gi), 64'(got), 64'(NTXN));
                chk($sformatf("cfg%0d_results_left", gi), 64'(exp_q.size()), 64'd0);
                done = 1'b1;
            end
        end
    endgenerate

    // ---------------- directed sequence ----------------
    initial begin : main
        logic [32:0] e;
        int lat;
        int seen;
        int w;

        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{"full_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[1] = '{"mixed",       32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0};
        vecs[2] = '{"zero",        32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[3] = '{"max_all",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{"msb_ovf",     32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5] = '{"cin_to_msb",  32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};
        vecs[6] = '{"chunk_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
        vecs[7] = '{"alt_bits",    32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 32'hFFFF_FFFF, 1'b0};

        rst0           = 1'b1;
        bus0.in_valid  = 1'b0;
        bus0.a         = '0;
        bus0.b         = '0;
        bus0.c_in      = 1'b0;
        bus0.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        chk("reset_in_ready",  64'(bus0.in_ready),  64'd1);
        chk("reset_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("reset_busy",      64'(bus0.busy),      64'd0);
        chk("reset_y",         64'(bus0.y),         64'd0);
        chk("reset_c_out",     64'(bus0.c_out),     64'd0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            send0(vecs[i].a, vecs[i].b, vecs[i].c_in, {vecs[i].c_out, vecs[i].y});
            chk({vecs[i].name, "_busy_in_run"}, 64'(bus0.busy), 64'd1);
            wait_out0(lat);
            chk({vecs[i].name, "_latency"}, 64'(lat), 64'd4);
            recv0(vecs[i].name);
        end

        // Backpressure: result must hold while out_ready is low; an in_valid
        // pulse during DONE must not be taken.
        e = {1'b0, 32'hEFBE_D001};
        send0(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, e);
        wait_out0(lat);
        chk("bp_latency", 64'(lat), 64'd4);
        for (int k = 0; k < 5; k++) begin
            bus0.out_ready = 1'b0;
            bus0.in_valid  = (k == 1);
            bus0.a         = 32'h0000_0001;
            bus0.b         = 32'h0000_0001;
            chk($sformatf("bp_hold%0d_result", k), 64'({bus0.c_out, bus0.y}), 64'(e));
            chk($sformatf("bp_hold%0d_in_ready", k), 64'(bus0.in_ready), 64'd0);
            chk($sformatf("bp_hold%0d_out_valid", k), 64'(bus0.out_valid), 64'd1);
            @(negedge clk);
        end
        bus0.in_valid = 1'b0;
        recv0("backpressure");
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus0.out_valid || bus0.busy) seen++;
        end
        chk("bp_pulse_ignored", 64'(seen), 64'd0);

        // Reset during the third RUN cycle
        send0(32'h1234_5678, 32'h1111_1111, 1'b0, {1'b0, 32'h2345_6789});
        @(negedge clk);
        @(negedge clk);
        chk("midrst_busy_before", 64'(bus0.busy), 64'd1);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        sb0.delete();
        chk("midrst_in_ready",  64'(bus0.in_ready),  64'd1);
        chk("midrst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("midrst_busy",      64'(bus0.busy),      64'd0);
        chk("midrst_y",         64'(bus0.y),         64'd0);
        chk("midrst_c_out",     64'(bus0.c_out),     64'd0);
        send0(32'd1, 32'd1, 1'b0, {1'b0, 32'd2});
        wait_out0(lat);
        chk("post_rst_latency", 64'(lat), 64'd4);
        recv0("post_reset_1p1");

        // Wait for the random engines
        w = 0;
        while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done) && w < 40000) begin
            @(negedge clk);
            w++;
        end
        chk("random_engines_done",
            64'({g_rand[2].done, g_rand[1].done, g_rand[0].done}), 64'd7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
